// File: rtl/uart_rx_frame.sv
`timescale 1ns/1ps
// Parametrised UART receiver: 2-flop input synchronizer, parity/framing/break/overrun
// detection and a valid/ready holding register. Define UART_RX_MAJORITY_EN for 2-of-3 sampling.
module uart_rx_frame #(
   parameter int BR        = 9600,
   parameter int CLK_RATE  = 50_000_000,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 1,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 serial_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_error,
   output logic                 framing_error,
   output logic                 overrun_error,
   output logic                 break_detect
);
   localparam int P    = CLK_RATE / BR;
   localparam int HALF = (P - 1) / 2;
   localparam int CW   = (P > 1) ? $clog2(P) : 1;

   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
   } state_t;

   state_t                 state_reg, state_next;
   logic [CW-1:0]          cnt_reg, cnt_next;
   logic [3:0]             bit_cnt_reg, bit_cnt_next;
   logic [DATA_BITS-1:0]   shift_reg, shift_next;
   logic                   acc_reg, acc_next;
   logic                   par_bit_reg, par_bit_next;
   logic                   par_fail_reg, par_fail_next;
   logic                   stop_fail_reg, stop_fail_next;
   logic                   sync1_reg, rxs_reg, sample;
   logic                   exp_par, stop_low;
   logic                   good_frame, par_err, frm_err, brk;
   logic [DATA_BITS-1:0]   rx_data_reg;
   logic                   rx_valid_reg, parity_error_reg, framing_error_reg;
   logic                   overrun_error_reg, break_detect_reg;

`ifdef UART_RX_MAJORITY_EN
   logic rxs_d1_reg, rxs_d2_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         rxs_d1_reg <= 1'b1;
         rxs_d2_reg <= 1'b1;
      end else begin
         rxs_d1_reg <= rxs_reg;
         rxs_d2_reg <= rxs_d1_reg;
      end
   end

   assign sample = (rxs_reg & rxs_d1_reg) | (rxs_reg & rxs_d2_reg) | (rxs_d1_reg & rxs_d2_reg);
`else
   assign sample = rxs_reg;
`endif

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      bit_cnt_next   = bit_cnt_reg;
      shift_next     = shift_reg;
      acc_next       = acc_reg;
      par_bit_next   = par_bit_reg;
      par_fail_next  = par_fail_reg;
      stop_fail_next = stop_fail_reg;
      exp_par        = (PARITY == 2) ? ~acc_reg : acc_reg;
      stop_low       = stop_fail_reg | ~sample;
      good_frame     = 1'b0;
      par_err        = 1'b0;
      frm_err        = 1'b0;
      brk            = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            cnt_next       = '0;
            bit_cnt_next   = '0;
            acc_next       = 1'b0;
            par_bit_next   = 1'b0;
            par_fail_next  = 1'b0;
            stop_fail_next = 1'b0;
            if (!rxs_reg) state_next = ST_START;
         end
         ST_START: begin
            if (cnt_reg == CW'(HALF)) begin
               cnt_next   = '0;
               state_next = sample ? ST_IDLE : ST_DATA;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_reg == CW'(P - 1)) begin
               cnt_next   = '0;
               shift_next = {sample, shift_reg[DATA_BITS-1:1]};
               acc_next   = acc_reg ^ sample;
               if (bit_cnt_reg == 4'(DATA_BITS - 1)) begin
                  bit_cnt_next = '0;
                  state_next   = (PARITY != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 1'b1;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_PARITY: begin
            if (cnt_reg == CW'(P - 1)) begin
               cnt_next      = '0;
               par_bit_next  = sample;
               par_fail_next = (sample != exp_par);
               state_next    = ST_STOP;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_STOP: begin
            if (cnt_reg == CW'(P - 1)) begin
               cnt_next = '0;
               if (bit_cnt_reg == 4'(STOP_BITS - 1)) begin
                  // Break outranks framing: an all-zero frame with a low stop is a held line.
                  if (stop_low && shift_reg == '0 && !par_bit_reg) begin
                     brk        = 1'b1;
                     state_next = ST_BREAK;
                  end else begin
                     frm_err    = stop_low;
                     par_err    = !stop_low && par_fail_reg;
                     good_frame = !stop_low && !par_fail_reg;
                     state_next = ST_IDLE;
                  end
               end else begin
                  bit_cnt_next   = bit_cnt_reg + 1'b1;
                  stop_fail_next = stop_low;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_BREAK: begin
            if (rxs_reg) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_reg         <= 1'b1;
         rxs_reg           <= 1'b1;
         state_reg         <= ST_IDLE;
         cnt_reg           <= '0;
         bit_cnt_reg       <= '0;
         shift_reg         <= '0;
         acc_reg           <= 1'b0;
         par_bit_reg       <= 1'b0;
         par_fail_reg      <= 1'b0;
         stop_fail_reg     <= 1'b0;
         rx_data_reg       <= '0;
         rx_valid_reg      <= 1'b0;
         parity_error_reg  <= 1'b0;
         framing_error_reg <= 1'b0;
         overrun_error_reg <= 1'b0;
         break_detect_reg  <= 1'b0;
      end else begin
         sync1_reg         <= serial_in;
         rxs_reg           <= sync1_reg;
         state_reg         <= state_next;
         cnt_reg           <= cnt_next;
         bit_cnt_reg       <= bit_cnt_next;
         shift_reg         <= shift_next;
         acc_reg           <= acc_next;
         par_bit_reg       <= par_bit_next;
         par_fail_reg      <= par_fail_next;
         stop_fail_reg     <= stop_fail_next;
         parity_error_reg  <= par_err;
         framing_error_reg <= frm_err;
         break_detect_reg  <= brk;
         overrun_error_reg <= good_frame && rx_valid_reg && !rx_ready;
         // A word accepted in the same cycle frees the slot for the new one.
         if (good_frame && !(rx_valid_reg && !rx_ready)) begin
            rx_data_reg  <= shift_reg;
            rx_valid_reg <= 1'b1;
         end else if (rx_valid_reg && rx_ready) begin
            rx_valid_reg <= 1'b0;
         end
      end
   end

   assign rx_data       = rx_data_reg;
   assign rx_valid      = rx_valid_reg;
   assign parity_error  = parity_error_reg;
   assign framing_error = framing_error_reg;
   assign overrun_error = overrun_error_reg;
   assign break_detect  = break_detect_reg;
endmodule

// File: tb/tb_uart_rx_frame.sv
`timescale 1ns/1ps
// Bench for uart_rx_frame: four instances (8E1, 8O1, 8N2, 7N1) share one RX line; a monitor
// logs events of the instance under test and each scenario compares them against its queue.
module tb_uart_rx_frame;
   localparam int CR = 160;
   localparam int BRT = 10;
   localparam int P = 16;
   localparam int HALF = 7;
   localparam int K_GOOD = 0, K_PAR = 1, K_FRM = 2, K_OVR = 3, K_BRK = 4;

   typedef struct {
      int         kind;
      logic [8:0] data;
      int         cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       serial_in = 1'b1;
   logic [3:0] rdy = '0;
   logic [3:0] rv, pe, fe, oe, bd;
   logic [7:0] rd0, rd1, rd2;
   logic [6:0] rd3;
   int         cyc = 0;
   int         mon_inst = 0;
   logic       rv_prev = 1'b0;
   int         n_tests = 0;
   int         n_fail = 0;
   ev_t        exp_q[$];
   ev_t        obs_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_frame #(.BR(BRT), .CLK_RATE(CR), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
      .clk(clk), .reset(reset), .serial_in(serial_in), .rx_data(rd0), .rx_valid(rv[0]),
      .rx_ready(rdy[0]), .parity_error(pe[0]), .framing_error(fe[0]),
      .overrun_error(oe[0]), .break_detect(bd[0]));
   uart_rx_frame #(.BR(BRT), .CLK_RATE(CR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
      .clk(clk), .reset(reset), .serial_in(serial_in), .rx_data(rd1), .rx_valid(rv[1]),
      .rx_ready(rdy[1]), .parity_error(pe[1]), .framing_error(fe[1]),
      .overrun_error(oe[1]), .break_detect(bd[1]));
   uart_rx_frame #(.BR(BRT), .CLK_RATE(CR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
      .clk(clk), .reset(reset), .serial_in(serial_in), .rx_data(rd2), .rx_valid(rv[2]),
      .rx_ready(rdy[2]), .parity_error(pe[2]), .framing_error(fe[2]),
      .overrun_error(oe[2]), .break_detect(bd[2]));
   uart_rx_frame #(.BR(BRT), .CLK_RATE(CR), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1)) u_7n1 (
      .clk(clk), .reset(reset), .serial_in(serial_in), .rx_data(rd3), .rx_valid(rv[3]),
      .rx_ready(rdy[3]), .parity_error(pe[3]), .framing_error(fe[3]),
      .overrun_error(oe[3]), .break_detect(bd[3]));

   function automatic logic [8:0] rdata(input int i);
      case (i)
         0:       return {1'b0, rd0};
         1:       return {1'b0, rd1};
         2:       return {1'b0, rd2};
         default: return {2'b0, rd3};
      endcase
   endfunction

   always @(negedge clk) begin
      ev_t ev;
      ev.cyc  = cyc;
      ev.data = rdata(mon_inst);
      if (!reset) begin
         if (rv[mon_inst] && !rv_prev) begin ev.kind = K_GOOD; obs_q.push_back(ev); end
         if (pe[mon_inst]) begin ev.kind = K_PAR; obs_q.push_back(ev); end
         if (fe[mon_inst]) begin ev.kind = K_FRM; obs_q.push_back(ev); end
         if (oe[mon_inst]) begin ev.kind = K_OVR; obs_q.push_back(ev); end
         if (bd[mon_inst]) begin ev.kind = K_BRK; obs_q.push_back(ev); end
      end
      rv_prev <= rv[mon_inst];
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int inst);
      @(negedge clk);
      mon_inst  = inst;
      reset     = 1'b1;
      serial_in = 1'b1;
      rdy       = '0;
      tick(3);
      reset = 1'b0;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic push_exp(input int kind, input logic [8:0] data);
      ev_t e;
      e.kind = kind;
      e.data = data;
      e.cyc  = 0;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [8:0] d, input int db, input int par,
                       input logic [1:0] stops, input int ns, input int spike);
      logic [15:0] bits;
      int          nb;
      bits    = '1;
      bits[0] = 1'b0;
      for (int j = 0; j < db; j++) bits[1+j] = d[j];
      nb = 1 + db;
      if (par >= 0) begin
         bits[nb] = par[0];
         nb++;
      end
      for (int s = 0; s < ns; s++) bits[nb+s] = stops[s];
      nb += ns;
      for (int i = 0; i < nb * P; i++) begin
         serial_in = bits[i/P] ^ (i == spike);
         @(negedge clk);
      end
      serial_in = 1'b1;
   endtask

   task automatic wait_obs(input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (obs_q.size() >= n) break;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      do_reset(0);
      send(9'h0A5, 8, 0, 2'b11, 1, -1);
      tick(4);
      @(negedge clk);
      reset = 1'b1;
      tick(2);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if ({rv[i], pe[i], fe[i], oe[i], bd[i]} !== 5'b0 || rdata(i) !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_values inst %0d: got flags %b data %h, expected 00000 and 000",
                     i, {rv[i], pe[i], fe[i], oe[i], bd[i]}, rdata(i));
         end
      end
      reset = 1'b0;
      obs_q.delete();
      // Abort mid-frame: the line rises during data bits after the reset.
      serial_in = 1'b0;
      tick(60);
      reset     = 1'b1;
      serial_in = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(400);
      n_tests++;
      if (obs_q.size() !== 0 || rv[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_midframe: got %0d events rx_valid %b, expected 0 events rx_valid 0",
                  obs_q.size(), rv[0]);
      end
   endtask

   task automatic test_good_even();
      ev_t e, o;
      int  c0;
      do_reset(0);
      push_exp(K_GOOD, 9'h0A5);
      c0 = cyc;
      send(9'h0A5, 8, 0, 2'b11, 1, -1);
      wait_obs(1, 50);
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
         n_fail++;
         $display("FAIL good_even_event: got no event, expected kind %0d data %h", e.kind, e.data);
      end else begin
         o = obs_q.pop_front();
         $display("[TB] 8E1 event kind %0d data %h at cycle %0d", o.kind, o.data, o.cyc);
         if (o.kind !== e.kind || o.data !== e.data) begin
            n_fail++;
            $display("FAIL good_even_event: got kind %0d data %h, expected kind %0d data %h",
                     o.kind, o.data, e.kind, e.data);
         end
         n_tests++;
         if (o.cyc - c0 !== 3 + HALF + P * 10 + 1) begin
            n_fail++;
            $display("FAIL good_even_latency: got %0d cycles, expected %0d", o.cyc - c0,
                     3 + HALF + P * 10 + 1);
         end
      end
      tick(20);
      n_tests++;
      if (rv[0] !== 1'b1 || rd0 !== 8'hA5) begin
         n_fail++;
         $display("FAIL good_even_hold: got valid %b data %h, expected 1 a5", rv[0], rd0);
      end
      rdy[0] = 1'b1;
      tick(1);
      rdy[0] = 1'b0;
      n_tests++;
      if (rv[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL good_even_accept: got valid %b, expected 0", rv[0]);
      end
      tick(5);
      n_tests++;
      if (obs_q.size() !== 0) begin
         n_fail++;
         $display("FAIL good_even_extra: got %0d extra events, expected 0", obs_q.size());
      end
   endtask

   task automatic test_parity_error();
      ev_t e, o;
      do_reset(1);
      push_exp(K_PAR, 9'h000);
      send(9'h03C, 8, 0, 2'b11, 1, -1);
      wait_obs(1, 50);
      tick(5);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_tests++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL parity_event: got no event, expected kind %0d data %h", e.kind, e.data);
         end else begin
            o = obs_q.pop_front();
            $display("[TB] 8O1 event kind %0d data %h at cycle %0d", o.kind, o.data, o.cyc);
            if (o.kind !== e.kind || o.data !== e.data) begin
               n_fail++;
               $display("FAIL parity_event: got kind %0d data %h, expected kind %0d data %h",
                        o.kind, o.data, e.kind, e.data);
            end
         end
      end
      n_tests++;
      if (obs_q.size() !== 0 || rv[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL parity_after: got %0d extra events valid %b, expected 0 and 0",
                  obs_q.size(), rv[1]);
      end
   endtask

   task automatic test_framing();
      ev_t e, o;
      do_reset(2);
      push_exp(K_FRM, 9'h000);
      push_exp(K_GOOD, 9'h042);
      send(9'h081, 8, -1, 2'b01, 2, -1);
      tick(32);
      send(9'h042, 8, -1, 2'b11, 2, -1);
      wait_obs(2, 50);
      tick(5);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_tests++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL framing_event: got no event, expected kind %0d data %h", e.kind, e.data);
         end else begin
            o = obs_q.pop_front();
            $display("[TB] 8N2 event kind %0d data %h at cycle %0d", o.kind, o.data, o.cyc);
            if (o.kind !== e.kind || o.data !== e.data) begin
               n_fail++;
               $display("FAIL framing_event: got kind %0d data %h, expected kind %0d data %h",
                        o.kind, o.data, e.kind, e.data);
            end
         end
      end
      n_tests++;
      if (obs_q.size() !== 0 || rv[2] !== 1'b1 || rd2 !== 8'h42) begin
         n_fail++;
         $display("FAIL framing_after: got %0d extra events valid %b data %h, expected 0 1 42",
                  obs_q.size(), rv[2], rd2);
      end
   endtask

   task automatic test_break();
      ev_t e, o;
      do_reset(0);
      push_exp(K_BRK, 9'h000);
      push_exp(K_GOOD, 9'h05A);
      serial_in = 1'b0;
      tick(15 * P);
      n_tests++;
      if (obs_q.size() !== 1) begin
         n_fail++;
         $display("FAIL break_single: got %0d events while low, expected 1", obs_q.size());
      end
      serial_in = 1'b1;
      tick(40);
      send(9'h05A, 8, 0, 2'b11, 1, -1);
      wait_obs(2, 50);
      tick(5);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_tests++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL break_event: got no event, expected kind %0d data %h", e.kind, e.data);
         end else begin
            o = obs_q.pop_front();
            $display("[TB] 8E1 event kind %0d data %h at cycle %0d", o.kind, o.data, o.cyc);
            if (o.kind !== e.kind || o.data !== e.data) begin
               n_fail++;
               $display("FAIL break_event: got kind %0d data %h, expected kind %0d data %h",
                        o.kind, o.data, e.kind, e.data);
            end
         end
      end
      n_tests++;
      if (obs_q.size() !== 0) begin
         n_fail++;
         $display("FAIL break_extra: got %0d extra events, expected 0", obs_q.size());
      end
   endtask

   task automatic test_overrun();
      ev_t e, o;
      int  c_first;
      do_reset(3);
      push_exp(K_GOOD, 9'h011);
      push_exp(K_OVR, 9'h011);
      send(9'h011, 7, -1, 2'b11, 1, -1);
      send(9'h022, 7, -1, 2'b11, 1, -1);
      wait_obs(2, 50);
      tick(5);
      c_first = -1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_tests++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL overrun_event: got no event, expected kind %0d data %h", e.kind, e.data);
         end else begin
            o = obs_q.pop_front();
            $display("[TB] 7N1 event kind %0d data %h at cycle %0d", o.kind, o.data, o.cyc);
            if (o.kind !== e.kind || o.data !== e.data) begin
               n_fail++;
               $display("FAIL overrun_event: got kind %0d data %h, expected kind %0d data %h",
                        o.kind, o.data, e.kind, e.data);
            end
            if (c_first < 0) begin
               c_first = o.cyc;
            end else begin
               n_tests++;
               if (o.cyc - c_first !== 9 * P) begin
                  n_fail++;
                  $display("FAIL overrun_spacing: got %0d cycles, expected %0d",
                           o.cyc - c_first, 9 * P);
               end
            end
         end
      end
      n_tests++;
      if (obs_q.size() !== 0 || rv[3] !== 1'b1 || rd3 !== 7'h11) begin
         n_fail++;
         $display("FAIL overrun_hold: got %0d extra events valid %b data %h, expected 0 1 11",
                  obs_q.size(), rv[3], rd3);
      end

      // Accept the first word exactly in the cycle the second frame completes.
      do_reset(3);
      push_exp(K_GOOD, 9'h011);
      fork
         begin
            send(9'h011, 7, -1, 2'b11, 1, -1);
            send(9'h022, 7, -1, 2'b11, 1, -1);
         end
         begin
            for (int i = 0; i < 400; i++) begin
               if (rv[3]) break;
               @(negedge clk);
            end
            tick(9 * P - 1);
            rdy[3] = 1'b1;
            tick(1);
            rdy[3] = 1'b0;
            n_tests++;
            if (rv[3] !== 1'b1 || rd3 !== 7'h22 || oe[3] !== 1'b0) begin
               n_fail++;
               $display("FAIL overrun_same_cycle: got valid %b data %h ovr %b, expected 1 22 0",
                        rv[3], rd3, oe[3]);
            end
         end
      join
      tick(5);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_tests++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL accept_event: got no event, expected kind %0d data %h", e.kind, e.data);
         end else begin
            o = obs_q.pop_front();
            $display("[TB] 7N1 event kind %0d data %h at cycle %0d", o.kind, o.data, o.cyc);
            if (o.kind !== e.kind || o.data !== e.data) begin
               n_fail++;
               $display("FAIL accept_event: got kind %0d data %h, expected kind %0d data %h",
                        o.kind, o.data, e.kind, e.data);
            end
         end
      end
      n_tests++;
      if (obs_q.size() !== 0) begin
         n_fail++;
         $display("FAIL accept_extra: got %0d extra events, expected 0", obs_q.size());
      end
   endtask

   task automatic test_glitch();
      ev_t e, o;
      logic [8:0] spiked;
      do_reset(0);
      serial_in = 1'b0;
      tick(3);
      serial_in = 1'b1;
      tick(60);
      n_tests++;
      if (obs_q.size() !== 0 || rv[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_idle: got %0d events valid %b, expected 0 and 0",
                  obs_q.size(), rv[0]);
      end
`ifdef UART_RX_MAJORITY_EN
      spiked = 9'h000;
`else
      spiked = 9'h008;
`endif
      // High spike on the pin lands in rxs exactly at data bit 3's sample cycle.
      do_reset(2);
      push_exp(K_GOOD, spiked);
      send(9'h000, 8, -1, 2'b11, 2, 2 + HALF + 1 + P * 4 - 2);
      wait_obs(1, 50);
      tick(5);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_tests++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL spike_event: got no event, expected kind %0d data %h", e.kind, e.data);
         end else begin
            o = obs_q.pop_front();
            $display("[TB] 8N2 event kind %0d data %h at cycle %0d", o.kind, o.data, o.cyc);
            if (o.kind !== e.kind || o.data !== e.data) begin
               n_fail++;
               $display("FAIL spike_event: got kind %0d data %h, expected kind %0d data %h",
                        o.kind, o.data, e.kind, e.data);
            end
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, expected to finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_good_even();
      test_parity_error();
      test_framing();
      test_break();
      test_overrun();
      test_glitch();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver, the next generation of the team's 8-bit even-parity receiver. Supports configurable data width, parity mode and stop-bit count. Adds a valid/ready output handshake, overrun, framing and break detection, and a built-in input synchronizer. Sits between the board RX pin and the byte-consuming logic (command parser / RX FIFO).

## Interface
- `BR`, 9600, baud rate in Hz.
- `CLK_RATE`, 50e6, clock frequency in Hz. `P = CLK_RATE/BR` (integer, P >= 8). `HALF = (P-1)/2`.
- `DATA_BITS`, 8, data bits per frame, legal range 5..9.
- `PARITY`, 1, parity mode: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1, stop bits per frame, 1 or 2.
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `serial_in` in 1: asynchronous RX line, idle high.
- `rx_data` out DATA_BITS: received word, LSB received first.
- `rx_valid` out 1: `rx_data` holds an unread good frame.
- `rx_ready` in 1: consumer accepts `rx_data` when high with `rx_valid`.
- `parity_error` out 1: one-cycle pulse, frame dropped on parity mismatch.
- `framing_error` out 1: one-cycle pulse, stop bit sampled low (non-break).
- `overrun_error` out 1: one-cycle pulse, good frame lost because the holding register was full.
- `break_detect` out 1: one-cycle pulse, break condition recognised.

## Operation
- `serial_in` passes through 2 flops (reset value 1); all logic uses synchronized `rxs`.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: clear counters and parity accumulator. On `rxs==0`, go to START.
- START: count to HALF, then re-sample. If low, go to DATA with counter 0. If high (glitch), go to IDLE with no output.
- DATA: sample every P clocks. Shift into `rx_data` shadow LSB first and XOR into the parity accumulator. After DATA_BITS samples, go to PARITY (PARITY≠0) or STOP.
- PARITY: sample after P clocks. Expected bit is accumulator (even) or ~accumulator (odd). A mismatch sets a parity-fail flag; the frame continues to STOP so resync stays correct.
- STOP: sample STOP_BITS times, P apart. Any low stop sample means frame fail.
- Frame end, decided at the last stop sample, in priority order:
  - All data bits 0, parity bit 0 (if present) and stop low: pulse `break_detect`, go to BREAK.
  - Stop low otherwise: pulse `framing_error`, go to IDLE.
  - Parity fail: pulse `parity_error`, go to IDLE.
  - Otherwise, good frame; go to IDLE.
- BREAK: wait for `rxs==1`, then go to IDLE. Only one `break_detect` per break, regardless of length.
- Holding register:
  - A good frame loads `rx_data` and sets `rx_valid`.
  - `rx_valid` clears on `rx_valid && rx_ready`.
  - Good frame with `rx_valid` high and `rx_ready` low: new word dropped, old word kept, `overrun_error` pulses.
  - Good frame in the same cycle as acceptance: new word loads, `rx_valid` stays high, no overrun.
- Errored frames never touch `rx_data` or `rx_valid`.

## Timing
- Reset values: `rx_data=0`, `rx_valid=0`, all error/break pulses 0, FSM IDLE, counters 0, synchronizer flops 1.
- Reset mid-frame: the next edge aborts the frame and returns all reset values. A pending `rx_valid` word is lost.
- With t0 the first cycle `rxs==0` in IDLE:
  - Start check at t0+1+HALF.
  - Data bit k (0-based) sampled P·(k+1) cycles after the start check.
  - Parity and stop bits follow at P spacing.
- `rx_valid` and the error/break pulses assert on the cycle after the last stop sample.
- Pin-to-`rx_valid` latency is 2 cycles (synchronizer) plus the above.
- IDLE re-arms on the cycle after frame end. Back-to-back frames with one stop bit are received without loss.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Every sample (start check, data, parity, stop) is the 2-of-3 majority of `rxs` at the sample cycle and the two preceding cycles.
  - Sample cycle numbers are unchanged.
  - A single-cycle spike is rejected.
- Undefined: single sample of `rxs` at the sample cycle. No extra flops.

## Test plan
Benches use CLK_RATE=160, BR=10 (P=16, HALF=7).
- **Good frame, even parity:** 8E1, send 0xA5 with parity 0, `rx_ready` low → `rx_valid=1`, `rx_data=0xA5`, both held. Raise `rx_ready` for 1 cycle → `rx_valid=0` next cycle.
- **Parity error:** 8O1, send 0x3C with parity 0 (correct is 1) → `parity_error` pulses 1 cycle, `rx_valid` stays 0.
- **Framing error:** 8N2, send 0x81 with second stop bit low → `framing_error` pulse, no `rx_valid`. Next frame 0x42 is received correctly.
- **Break:** line held low 15 bit times → exactly one `break_detect`, no `rx_valid` or `framing_error`. FSM stays in BREAK until line high.
- **Overrun:** 7N1, frames 0x11 then 0x22 back to back with `rx_ready` low → `overrun_error` pulse at the second frame end, `rx_data=0x11`. Repeat with `rx_ready` high at the second frame end → `rx_data=0x22`, no overrun.
- **Glitch rejection:** 3-cycle low glitch in idle → no activity. With `UART_RX_MAJORITY_EN`, a 1-cycle high spike at a data sample point of 0x00 still yields 0x00. Without the macro, the same spike yields a corrupted word.
